projectile_engine: RTL and testbench

- Parametrised single-clock projectile engine: launches one projectile, integrates motion once per frame strobe, detects impact, then carves a circular crater into the terrain column stream.
- Sits between the turn/aim controller (supplies launch handshake and initial velocity) and the terrain RAM/renderer pipeline (supplies terrain column and draw coordinates).
- Successor to the fixed-size bomb block: parametrised geometry and physics, launch handshake, fuse timeout, multi-frame blast window, and an optional wind term.

---
 rtl/projectile_if.sv | 21 ++
 rtl/projectile_engine.sv | 192 +++++++++++++++++++
 tb/tb_projectile_engine.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/projectile_if.sv
// Launch handshake between the turn/aim controller (master) and the projectile engine (slave).
interface projectile_if #(
  parameter int COORD_W = 10
);
  logic                      launch_valid;
  logic                      launch_ready;
  logic        [COORD_W-1:0] launch_x;
  logic        [COORD_W-1:0] launch_y;
  logic signed [COORD_W-1:0] vel_x_init;
  logic signed [COORD_W-1:0] vel_y_init;

  modport master (
    output launch_valid, launch_x, launch_y, vel_x_init, vel_y_init,
    input  launch_ready
  );

  modport slave (
    input  launch_valid, launch_x, launch_y, vel_x_init, vel_y_init,
    output launch_ready
  );
endinterface

// File: rtl/projectile_engine.sv
// Projectile engine: launch, per-frame ballistic integration, impact detection and crater carving.
// Defining PROJECTILE_WIND_EN adds the wind port, which is added to vel_x on every gravity step.
module projectile_engine #(
  parameter int COORD_W      = 10,
  parameter int TERR_H       = 512,
  parameter int X_MIN        = 5,
  parameter int X_MAX        = 634,
  parameter int Y_MIN        = 5,
  parameter int Y_MAX        = 474,
  parameter int SIZE         = 4,
  parameter int V_MAX        = 12,
  parameter int GRAV_DIV     = 6,
  parameter int BLAST_R      = 14,
  parameter int BLAST_FRAMES = 2,
  parameter int FUSE_FRAMES  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  projectile_if.slave         launch,
  input  logic                terrain_hit,
  input  logic [COORD_W-1:0]  draw_x,
  input  logic [COORD_W-1:0]  draw_y,
  input  logic [TERR_H-1:0]   terrain_in,
  output logic [TERR_H-1:0]   terrain_out,
  output logic [COORD_W-1:0]  pos_x,
  output logic [COORD_W-1:0]  pos_y,
  output logic [COORD_W-1:0]  size,
  output logic                busy,
  output logic                exploded,
  output logic                blast_active
`ifdef PROJECTILE_WIND_EN
  ,
  input  logic signed [3:0]   wind
`endif
);

  typedef enum logic [1:0] {IDLE, FLIGHT, BLAST} state_t;

  localparam int VW = COORD_W + 2;
  localparam int DW = 2 * COORD_W + 3;
  localparam int GW = $clog2(GRAV_DIV + 1);
  localparam int FW = (FUSE_FRAMES > 0) ? $clog2(FUSE_FRAMES + 1) : 1;
  localparam int BW = $clog2(BLAST_FRAMES + 1);

  localparam logic signed [VW-1:0] VMAX_P = VW'(V_MAX);
  localparam logic signed [VW-1:0] VMAX_N = VW'(-V_MAX);
  localparam logic [COORD_W-1:0] X_LO  = COORD_W'(X_MIN + SIZE);
  localparam logic [COORD_W-1:0] X_HI  = COORD_W'(X_MAX - SIZE);
  localparam logic [COORD_W-1:0] Y_LO  = COORD_W'(Y_MIN + SIZE);
  localparam logic [COORD_W-1:0] Y_HI  = COORD_W'(Y_MAX - SIZE);
  localparam logic [COORD_W-1:0] X_RST = COORD_W'(X_MAX / 2);
  localparam logic [COORD_W-1:0] Y_RST = COORD_W'(Y_MIN + SIZE + 1);
  localparam logic [DW-1:0]      R2    = DW'(BLAST_R * BLAST_R);
  localparam logic [TERR_H-1:0]  ONE   = TERR_H'(1);

  function automatic logic signed [VW-1:0] sext(input logic signed [COORD_W-1:0] v);
    return {{2{v[COORD_W-1]}}, v};
  endfunction

  function automatic logic signed [COORD_W-1:0] clamp_v(input logic signed [VW-1:0] v);
    if (v > VMAX_P) return VMAX_P[COORD_W-1:0];
    if (v < VMAX_N) return VMAX_N[COORD_W-1:0];
    return v[COORD_W-1:0];
  endfunction

  state_t                    state, next_state;
  logic signed [COORD_W-1:0] vel_x, vel_y;
  logic signed [COORD_W-1:0] vx_next, vy_next;
  logic signed [VW-1:0]      wind_add;
  logic        [GW-1:0]      grav_cnt;
  logic        [FW-1:0]      fuse_cnt;
  logic        [BW-1:0]      blast_cnt;
  logic                      grav_wrap, fuse_out, impact;
  logic                      do_launch, do_detonate, do_step, blast_step;

  assign size                = COORD_W'(SIZE);
  assign launch.launch_ready = (state == IDLE);
  assign busy                = (state == FLIGHT) || (state == BLAST);
  assign blast_active        = (state == BLAST);

  assign fuse_out  = (FUSE_FRAMES != 0) && (fuse_cnt == FW'(FUSE_FRAMES));
  assign impact    = terrain_hit || (pos_x <= X_LO) || (pos_x >= X_HI) ||
                     (pos_y <= Y_LO) || (pos_y >= Y_HI) || fuse_out;
  assign grav_wrap = (grav_cnt == GW'(GRAV_DIV - 1));

`ifdef PROJECTILE_WIND_EN
  assign wind_add = grav_wrap ? {{(VW-4){wind[3]}}, wind} : '0;
`else
  assign wind_add = '0;
`endif

  // Position always advances by the velocity held before this frame's gravity/wind update.
  assign vx_next = clamp_v(sext(vel_x) + wind_add);
  assign vy_next = clamp_v(sext(vel_y) + $signed(VW'(grav_wrap)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    do_launch   = 1'b0;
    do_detonate = 1'b0;
    do_step     = 1'b0;
    blast_step  = 1'b0;
    case (state)
      IDLE: begin
        if (launch.launch_valid) begin
          do_launch  = 1'b1;
          next_state = FLIGHT;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          if (impact) begin
            do_detonate = 1'b1;
            next_state  = BLAST;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      BLAST: begin
        if (frame_tick) begin
          blast_step = 1'b1;
          if (blast_cnt == BW'(BLAST_FRAMES - 1)) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x     <= X_RST;
      pos_y     <= Y_RST;
      vel_x     <= '0;
      vel_y     <= '0;
      grav_cnt  <= '0;
      fuse_cnt  <= '0;
      blast_cnt <= '0;
      exploded  <= 1'b0;
    end else begin
      exploded <= do_detonate;
      if (do_launch) begin
        pos_x    <= launch.launch_x;
        pos_y    <= launch.launch_y - COORD_W'(SIZE);
        vel_x    <= clamp_v(sext(launch.vel_x_init));
        vel_y    <= clamp_v(sext(launch.vel_y_init));
        grav_cnt <= '0;
        fuse_cnt <= '0;
      end
      if (do_detonate) begin
        vel_x     <= '0;
        vel_y     <= '0;
        blast_cnt <= '0;
      end
      if (do_step) begin
        pos_x    <= pos_x + $unsigned(vel_x);
        pos_y    <= pos_y + $unsigned(vel_y);
        vel_x    <= vx_next;
        vel_y    <= vy_next;
        grav_cnt <= grav_wrap ? '0 : grav_cnt + GW'(1);
        fuse_cnt <= (&fuse_cnt) ? fuse_cnt : fuse_cnt + FW'(1);
      end
      if (blast_step) blast_cnt <= blast_cnt + BW'(1);
    end
  end

  // Crater test uses the registered blast position; products are wide enough for any coordinate pair.
  logic signed [COORD_W:0]     dx, dy;
  logic signed [2*COORD_W+1:0] sq_x, sq_y;
  logic        [DW-1:0]        dist2;
  logic                        carve;

  always_comb begin
    dx    = $signed({1'b0, draw_x}) - $signed({1'b0, pos_x});
    dy    = $signed({1'b0, draw_y}) - $signed({1'b0, pos_y});
    sq_x  = dx * dx;
    sq_y  = dy * dy;
    dist2 = DW'($unsigned(sq_x)) + DW'($unsigned(sq_y));
    carve = blast_active && (dist2 <= R2) && (32'(draw_y) < TERR_H);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) terrain_out <= '0;
    else       terrain_out <= terrain_in & ~(carve ? (ONE << draw_y) : '0);
  end

endmodule

// File: tb/tb_projectile_engine.sv
// Self-checking bench for projectile_engine: a behavioural model pushes expected positions and
// terrain columns into queues that are popped when the DUT output is due.
module tb_projectile_engine;
  localparam int CW = 10;
  localparam int TH = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic          terrain_hit;
  logic [CW-1:0] draw_x, draw_y;
  logic [TH-1:0] terrain_in, terrain_out;
  logic [CW-1:0] pos_x, pos_y, size;
  logic          busy, exploded, blast_active;
`ifdef PROJECTILE_WIND_EN
  logic signed [3:0] wind;
`endif

  projectile_if #(.COORD_W(CW)) lif ();

  projectile_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(lif),
    .terrain_hit(terrain_hit), .draw_x(draw_x), .draw_y(draw_y),
    .terrain_in(terrain_in), .terrain_out(terrain_out),
    .pos_x(pos_x), .pos_y(pos_y), .size(size), .busy(busy),
    .exploded(exploded), .blast_active(blast_active)
`ifdef PROJECTILE_WIND_EN
    , .wind(wind)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int expl_cnt = 0;
  int m_px, m_py, m_vx, m_vy, m_g, m_wind;
  int q_px[$], q_py[$];
  logic [TH-1:0] q_terr[$];

  always @(negedge clk) if (exploded) expl_cnt++;

  function automatic int clampi(input int v);
    if (v > 12) return 12;
    if (v < -12) return -12;
    return v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hard_reset();
    reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
  endtask

  task automatic do_launch(input int x, input int y, input int vx, input int vy, input bit with_tick);
    lif.launch_x = CW'(x); lif.launch_y = CW'(y);
    lif.vel_x_init = CW'(vx); lif.vel_y_init = CW'(vy);
    lif.launch_valid = 1'b1; frame_tick = with_tick;
    cyc(1);
    lif.launch_valid = 1'b0; frame_tick = 1'b0;
    m_px = x; m_py = y - 4; m_vx = clampi(vx); m_vy = clampi(vy); m_g = 0;
  endtask

  task automatic frame(input bit hit);
    frame_tick = 1'b1; terrain_hit = hit; cyc(1);
    frame_tick = 1'b0; terrain_hit = 1'b0; cyc(1);
  endtask

  // Model of one flight step: move with the current velocity, then apply gravity/wind.
  task automatic model_tick();
    m_px = (m_px + m_vx) & 1023;
    m_py = (m_py + m_vy) & 1023;
    m_g++;
    if (m_g == 6) begin
      m_g = 0;
      m_vy = clampi(m_vy + 1);
      m_vx = clampi(m_vx + m_wind);
    end
    q_px.push_back(m_px);
    q_py.push_back(m_py);
  endtask

  task automatic test_reset();
    chk_cnt++; if (lif.launch_ready !== 1'b1) $display("[TB] FAIL rst_ready got %b want 1", lif.launch_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (pos_x !== 10'd317) $display("[TB] FAIL rst_pos_x got %0d want 317", pos_x); else pass_cnt++;
    chk_cnt++; if (pos_y !== 10'd10) $display("[TB] FAIL rst_pos_y got %0d want 10", pos_y); else pass_cnt++;
    chk_cnt++; if (terrain_out !== '0) $display("[TB] FAIL rst_terrain got %h want 0", terrain_out); else pass_cnt++;
    chk_cnt++; if (exploded !== 1'b0 || blast_active !== 1'b0) $display("[TB] FAIL rst_blast got %b%b want 00", exploded, blast_active); else pass_cnt++;
    chk_cnt++; if (size !== 10'd4) $display("[TB] FAIL size got %0d want 4", size); else pass_cnt++;
  endtask

  task automatic test_flight();
    int ex, ey;
    hard_reset();
    do_launch(100, 300, 3, -5, 1'b0);
    chk_cnt++; if (pos_x !== 10'd100 || pos_y !== 10'd296) $display("[TB] FAIL launch_pos got (%0d,%0d) want (100,296)", pos_x, pos_y); else pass_cnt++;
    chk_cnt++; if (lif.launch_ready !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL flight_flags got ready=%b busy=%b want 0 1", lif.launch_ready, busy); else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      model_tick();
      frame(1'b0);
      ex = q_px.pop_front(); ey = q_py.pop_front();
      chk_cnt++; if (pos_x !== CW'(ex) || pos_y !== CW'(ey)) $display("[TB] FAIL flight_tick%0d got (%0d,%0d) want (%0d,%0d)", i + 1, pos_x, pos_y, ex, ey); else pass_cnt++;
      if (i == 5) begin
        chk_cnt++; if (pos_x !== 10'd118 || pos_y !== 10'd266) $display("[TB] FAIL flight_six got (%0d,%0d) want (118,266)", pos_x, pos_y); else pass_cnt++;
      end
    end
    chk_cnt++; if (pos_y !== 10'd262) $display("[TB] FAIL vel_y_after_grav got y=%0d want 262", pos_y); else pass_cnt++;
  endtask

  task automatic test_clamp();
    int ex, ey;
    hard_reset();
    do_launch(300, 400, 20, -20, 1'b1);
    cyc(1);
    chk_cnt++; if (pos_x !== 10'd300 || pos_y !== 10'd396) $display("[TB] FAIL launch_tick_ignored got (%0d,%0d) want (300,396)", pos_x, pos_y); else pass_cnt++;
    frame(1'b0);
    chk_cnt++; if (pos_x !== 10'd312 || pos_y !== 10'd384) $display("[TB] FAIL clamp_launch got (%0d,%0d) want (312,384)", pos_x, pos_y); else pass_cnt++;
    hard_reset();
    do_launch(320, 30, 0, 11, 1'b0);
    for (int i = 0; i < 18; i++) begin
      model_tick();
      frame(1'b0);
      ex = q_px.pop_front(); ey = q_py.pop_front();
      if (i >= 11) begin
        chk_cnt++; if (pos_x !== CW'(ex) || pos_y !== CW'(ey)) $display("[TB] FAIL sat_tick%0d got (%0d,%0d) want (%0d,%0d)", i + 1, pos_x, pos_y, ex, ey); else pass_cnt++;
      end
    end
    chk_cnt++; if (pos_y !== 10'd236) $display("[TB] FAIL sat_final got y=%0d want 236", pos_y); else pass_cnt++;
  endtask

  task automatic test_hit();
    hard_reset();
    expl_cnt = 0;
    do_launch(100, 300, 1, 0, 1'b0);
    repeat (3) frame(1'b0);
    frame_tick = 1'b1; terrain_hit = 1'b1; cyc(1);
    frame_tick = 1'b0; terrain_hit = 1'b0;
    chk_cnt++; if (exploded !== 1'b1) $display("[TB] FAIL exploded_pulse got %b want 1", exploded); else pass_cnt++;
    chk_cnt++; if (blast_active !== 1'b1 || busy !== 1'b1 || lif.launch_ready !== 1'b0) $display("[TB] FAIL blast_enter got act=%b busy=%b rdy=%b want 1 1 0", blast_active, busy, lif.launch_ready); else pass_cnt++;
    chk_cnt++; if (pos_x !== 10'd103 || pos_y !== 10'd296) $display("[TB] FAIL hit_pos got (%0d,%0d) want (103,296)", pos_x, pos_y); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (exploded !== 1'b0) $display("[TB] FAIL exploded_clear got %b want 0", exploded); else pass_cnt++;
    lif.launch_x = 10'd50; lif.launch_y = 10'd50; lif.launch_valid = 1'b1; cyc(1); lif.launch_valid = 1'b0;
    frame(1'b0);
    chk_cnt++; if (blast_active !== 1'b1) $display("[TB] FAIL blast_hold got %b want 1", blast_active); else pass_cnt++;
    frame(1'b0);
    chk_cnt++; if (blast_active !== 1'b0 || busy !== 1'b0 || lif.launch_ready !== 1'b1) $display("[TB] FAIL blast_exit got act=%b busy=%b rdy=%b want 0 0 1", blast_active, busy, lif.launch_ready); else pass_cnt++;
    chk_cnt++; if (pos_x !== 10'd103 || pos_y !== 10'd296) $display("[TB] FAIL launch_in_blast got (%0d,%0d) want (103,296)", pos_x, pos_y); else pass_cnt++;
    chk_cnt++; if (expl_cnt !== 1) $display("[TB] FAIL exploded_count got %0d want 1", expl_cnt); else pass_cnt++;
  endtask

  task automatic test_bounds();
    hard_reset();
    do_launch(12, 200, -3, 0, 1'b0);
    frame(1'b0);
    chk_cnt++; if (blast_active !== 1'b0 || pos_x !== 10'd9) $display("[TB] FAIL bound_pre got act=%b x=%0d want 0 9", blast_active, pos_x); else pass_cnt++;
    frame(1'b0);
    chk_cnt++; if (blast_active !== 1'b1 || pos_x !== 10'd9) $display("[TB] FAIL bound_hit got act=%b x=%0d want 1 9", blast_active, pos_x); else pass_cnt++;
  endtask

  // Crater centred at (200,200), radius 14; the first pass is in BLAST, the second after return to IDLE.
  task automatic test_carve();
    int pts_x[8] = '{210, 211, 200, 200, 186, 214, 215, 190};
    int pts_y[8] = '{210, 210, 186, 185, 200, 200, 200, 195};
    logic [TH-1:0] tin, exp_t, got_t;
    int dx, dy;
    hard_reset();
    do_launch(200, 204, 0, 0, 1'b0);
    frame(1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        if (i < 2) tin = '1;
        else for (int k = 0; k < TH / 32; k++) tin[k*32 +: 32] = $urandom();
        draw_x = CW'(pts_x[i]); draw_y = CW'(pts_y[i]); terrain_in = tin;
        exp_t = tin;
        dx = pts_x[i] - 200; dy = pts_y[i] - 200;
        if (pass == 0 && dx * dx + dy * dy <= 196 && pts_y[i] < TH) exp_t[pts_y[i]] = 1'b0;
        q_terr.push_back(exp_t);
        cyc(1);
        got_t = q_terr.pop_front();
        chk_cnt++; if (terrain_out !== got_t) $display("[TB] FAIL carve_p%0d_%0d got bit=%b want bit=%b", pass, i, terrain_out[pts_y[i]], got_t[pts_y[i]]); else pass_cnt++;
      end
      if (pass == 0) begin frame(1'b0); frame(1'b0); end
    end
  endtask

  task automatic test_reset_midflight();
    hard_reset();
    do_launch(100, 300, 3, -5, 1'b0);
    frame(1'b0); frame(1'b0);
    terrain_in = '1;
    reset = 1'b1; #1;
    chk_cnt++; if (lif.launch_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL mid_rst_flags got rdy=%b busy=%b want 1 0", lif.launch_ready, busy); else pass_cnt++;
    chk_cnt++; if (pos_x !== 10'd317 || pos_y !== 10'd10) $display("[TB] FAIL mid_rst_pos got (%0d,%0d) want (317,10)", pos_x, pos_y); else pass_cnt++;
    cyc(1);
    chk_cnt++; if (terrain_out !== '0) $display("[TB] FAIL mid_rst_terrain got nonzero want 0"); else pass_cnt++;
    reset = 1'b0; cyc(1);
    chk_cnt++; if (terrain_out !== {TH{1'b1}}) $display("[TB] FAIL post_rst_pass got %h want all ones", terrain_out[31:0]); else pass_cnt++;
  endtask

`ifdef PROJECTILE_WIND_EN
  task automatic test_wind();
    int ex, ey;
    hard_reset();
    wind = -4'sd2; m_wind = -2;
    do_launch(300, 300, 3, 0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      model_tick();
      frame(1'b0);
      ex = q_px.pop_front(); ey = q_py.pop_front();
      chk_cnt++; if (pos_x !== CW'(ex) || pos_y !== CW'(ey)) $display("[TB] FAIL wind_tick%0d got (%0d,%0d) want (%0d,%0d)", i + 1, pos_x, pos_y, ex, ey); else pass_cnt++;
    end
    chk_cnt++; if (pos_x !== 10'd323) $display("[TB] FAIL wind_final got x=%0d want 323", pos_x); else pass_cnt++;
    wind = 4'sd0; m_wind = 0;
  endtask
`endif

  initial begin
    reset = 1'b1; frame_tick = 1'b0; terrain_hit = 1'b0;
    draw_x = '0; draw_y = '0; terrain_in = '0;
    lif.launch_valid = 1'b0; lif.launch_x = '0; lif.launch_y = '0;
    lif.vel_x_init = '0; lif.vel_y_init = '0;
    m_wind = 0;
`ifdef PROJECTILE_WIND_EN
    wind = 4'sd0;
`endif
    cyc(2);
    test_reset();
    reset = 1'b0;
    cyc(1);
    test_flight();
    test_clamp();
    test_hit();
    test_bounds();
    test_carve();
    test_reset_midflight();
`ifdef PROJECTILE_WIND_EN
    test_wind();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
